// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-ported memory, with a watchdog on each access.
// Latency: request seen in IDLE -> m_valid next cycle; m_ready -> rN_ready next cycle -> IDLE the cycle after.
// Backpressure: a requester holds valid until its ready pulse; the memory stalls with m_ready=0 until the watchdog aborts.
module mem_arbiter #(
  parameter int W  = 8,
  parameter int D  = 16,
  parameter int TO = 16,
  localparam int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_valid,
  input  logic          r0_wrd,
  input  logic [AW-1:0] r0_addr,
  input  logic [W-1:0]  r0_wdata,
  output logic          r0_ready,
  output logic          r0_err,
  output logic [W-1:0]  r0_rdata,
  input  logic          r1_valid,
  input  logic          r1_wrd,
  input  logic [AW-1:0] r1_addr,
  input  logic [W-1:0]  r1_wdata,
  output logic          r1_ready,
  output logic          r1_err,
  output logic [W-1:0]  r1_rdata,
  output logic          m_valid,
  output logic          m_wrd,
  output logic [AW-1:0] m_addr,
  output logic [W-1:0]  m_wdata,
  input  logic          m_ready,
  input  logic [W-1:0]  m_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  // Abort happens in the ISSUE cycle whose stall makes the watchdog reach TO-1,
  // so m_valid stays high for TO-1 cycles on a memory that never answers.
  localparam logic [7:0] WD_ABORT = 8'(TO - 2);

  state_t         state;
  state_t         state_nx;
  logic           last_grant;
  logic           grant;
  logic [7:0]     wdog;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;

  logic           pick;
  logic           do_grant;
  logic           do_ok;
  logic           do_abort;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: arbitration in IDLE, completion or watchdog abort in ISSUE
  always_comb begin
    state_nx = state;
    pick     = 1'b0;
    do_grant = 1'b0;
    do_ok    = 1'b0;
    do_abort = 1'b0;
    case (state)
      IDLE: begin
        if (r0_valid || r1_valid) begin
          do_grant = 1'b1;
          // On a tie the requester that did not win last time goes first
          pick     = (r0_valid && r1_valid) ? ~last_grant : r1_valid;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        // m_ready is checked first so a response on the final watchdog cycle still succeeds
        if (m_ready) begin
          do_ok    = 1'b1;
          state_nx = DONE;
        end else if (wdog == WD_ABORT) begin
          do_abort = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Datapath: latch the granted command, run the watchdog, capture the response
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      grant      <= 1'b0;
      wdog       <= 8'd0;
      m_valid    <= 1'b0;
      m_wrd      <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (do_grant) begin
        grant      <= pick;
        last_grant <= pick;
        wdog       <= 8'd0;
        m_valid    <= 1'b1;
        m_wrd      <= pick ? r1_wrd   : r0_wrd;
        m_addr     <= pick ? r1_addr  : r0_addr;
        m_wdata    <= pick ? r1_wdata : r0_wdata;
      end else if (state == ISSUE && !m_ready) begin
        wdog <= wdog + 8'd1;
      end
      if (do_ok) begin
        m_valid  <= 1'b0;
        rsp_data <= m_wrd ? '0 : m_rdata;
        rsp_err  <= 1'b0;
      end
      if (do_abort) begin
        m_valid  <= 1'b0;
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end
    end
  end

  // Completion pulse goes only to the granted requester; data and error are masked otherwise
  assign r0_ready = (state == DONE) && !grant;
  assign r1_ready = (state == DONE) &&  grant;
  assign r0_rdata = r0_ready ? rsp_data : '0;
  assign r1_rdata = r1_ready ? rsp_data : '0;
  assign r0_err   = r0_ready & rsp_err;
  assign r1_err   = r1_ready & rsp_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model of the arbiter.
// The memory side is a bench-owned array with a random-latency responder.
module tb_mem_arbiter;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_valid, r0_wrd, r0_ready, r0_err;
  logic [AW-1:0] r0_addr;
  logic [W-1:0]  r0_wdata, r0_rdata;
  logic          r1_valid, r1_wrd, r1_ready, r1_err;
  logic [AW-1:0] r1_addr;
  logic [W-1:0]  r1_wdata, r1_rdata;
  logic          m_valid, m_wrd, m_ready;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_wdata, m_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.W(W), .D(D), .TO(TO)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_wrd(r0_wrd), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_wrd(r1_wrd), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .m_valid(m_valid), .m_wrd(m_wrd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] mem [D];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: the memory commits a write it acknowledges, then read data follows the address
  task automatic tick();
    if (m_valid && m_ready && m_wrd) mem[m_addr] = m_wdata;
    @(posedge clk);
    #2;
    m_rdata = mem[m_addr];
  endtask

  task automatic new_cmd(output logic wrd, output logic [AW-1:0] a, output logic [W-1:0] d);
    wrd = 1'($urandom_range(0, 1));
    a   = AW'($urandom);
    d   = W'($urandom);
  endtask

  // ---------------- transaction-level model ----------------
  // busy: one access is outstanding on the memory port; done: its completion is being reported.
  bit            chk_en = 1'b0;
  bit            mdl_busy, mdl_done, mdl_last, mdl_wrd, mdl_err;
  int            mdl_own, mdl_age;
  logic [AW-1:0] mdl_addr;
  logic [W-1:0]  mdl_wdata, mdl_rdata;

  always @(posedge clk) begin
    if (rst) begin
      chk_en   = 1'b1;
      mdl_busy = 1'b0;
      mdl_done = 1'b0;
      mdl_last = 1'b1;
      mdl_own  = 0;
      mdl_age  = 0;
    end else if (mdl_done) begin
      mdl_done = 1'b0;
    end else if (mdl_busy) begin
      if (m_ready) begin
        mdl_busy  = 1'b0;
        mdl_done  = 1'b1;
        mdl_err   = 1'b0;
        mdl_rdata = mdl_wrd ? '0 : m_rdata;
      end else if (mdl_age + 1 >= TO - 1) begin
        mdl_busy  = 1'b0;
        mdl_done  = 1'b1;
        mdl_err   = 1'b1;
        mdl_rdata = '0;
      end else begin
        mdl_age++;
      end
    end else if (r0_valid || r1_valid) begin
      if (r0_valid && r1_valid) mdl_own = mdl_last ? 0 : 1;
      else                      mdl_own = r1_valid ? 1 : 0;
      mdl_last  = (mdl_own == 1);
      mdl_busy  = 1'b1;
      mdl_age   = 0;
      mdl_wrd   = (mdl_own == 1) ? r1_wrd   : r0_wrd;
      mdl_addr  = (mdl_own == 1) ? r1_addr  : r0_addr;
      mdl_wdata = (mdl_own == 1) ? r1_wdata : r0_wdata;
    end
    #1;
    if (chk_en) begin
      chk("mdl_m_valid", m_valid, mdl_busy);
      if (mdl_busy) begin
        chk("mdl_m_wrd", m_wrd, mdl_wrd);
        chk("mdl_m_addr", m_addr, mdl_addr);
        chk("mdl_m_wdata", m_wdata, mdl_wdata);
      end
      chk("mdl_r0_ready", r0_ready, mdl_done && mdl_own == 0);
      chk("mdl_r1_ready", r1_ready, mdl_done && mdl_own == 1);
      chk("mdl_r0_err",   r0_err,   (mdl_done && mdl_own == 0) ? mdl_err : 1'b0);
      chk("mdl_r1_err",   r1_err,   (mdl_done && mdl_own == 1) ? mdl_err : 1'b0);
      chk("mdl_r0_rdata", r0_rdata, (mdl_done && mdl_own == 0) ? mdl_rdata : '0);
      chk("mdl_r1_rdata", r1_rdata, (mdl_done && mdl_own == 1) ? mdl_rdata : '0);
    end
  end

  // ---------------- stimulus and directed checks ----------------
  int   npulse, cnt, any_rdy, lat;
  bit   seen, wait_arm;
  logic e_err;
  logic [W-1:0] e_data;
  int   order [4];
  int   exp_order [4];

  initial begin
    rst = 1'b1;
    r0_valid = 1'b0; r0_wrd = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_valid = 1'b0; r1_wrd = 1'b0; r1_addr = '0; r1_wdata = '0;
    m_ready = 1'b0; m_rdata = '0;
    foreach (mem[i]) mem[i] = W'($urandom);
    exp_order = '{0, 1, 0, 1};
    tick();
    tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_r0_ready", r0_ready, 0);
    chk("rst_r1_ready", r1_ready, 0);
    chk("rst_m_addr", m_addr, 0);
    rst = 1'b0;

    // r0 write addr 3 = 0xA5, memory answers on the second ISSUE cycle
    r0_valid = 1'b1; r0_wrd = 1'b1; r0_addr = 4'd3; r0_wdata = 8'hA5;
    tick();
    chk("wr_m_valid", m_valid, 1);
    chk("wr_m_wrd", m_wrd, 1);
    chk("wr_m_addr", m_addr, 3);
    chk("wr_m_wdata", m_wdata, 8'hA5);
    tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0; r0_valid = 1'b0;
    chk("wr_r0_ready", r0_ready, 1);
    chk("wr_r0_err", r0_err, 0);
    chk("wr_m_valid_drop", m_valid, 0);
    tick();
    chk("wr_r0_ready_pulse", r0_ready, 0);

    // r1 read addr 3 returns 0xA5
    r1_valid = 1'b1; r1_wrd = 1'b0; r1_addr = 4'd3; r1_wdata = 8'h3C;
    tick();
    chk("rd_m_wrd", m_wrd, 0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0; r1_valid = 1'b0;
    chk("rd_r1_ready", r1_ready, 1);
    chk("rd_r1_rdata", r1_rdata, 8'hA5);
    chk("rd_r0_ready", r0_ready, 0);
    tick();

    // Both requesting continuously after reset: r0, r1, r0, r1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    r0_valid = 1'b1; r0_wrd = 1'b0; r0_addr = 4'd1;
    r1_valid = 1'b1; r1_wrd = 1'b0; r1_addr = 4'd2;
    npulse = 0;
    for (int c = 0; c < 40 && npulse < 4; c++) begin
      m_ready = m_valid;
      tick();
      if (r0_ready) begin order[npulse] = 0; npulse++; end
      else if (r1_ready) begin order[npulse] = 1; npulse++; end
    end
    r0_valid = 1'b0; r1_valid = 1'b0; m_ready = 1'b0;
    chk("rr_pulses", npulse, 4);
    for (int i = 0; i < 4; i++) chk("rr_order", order[i], exp_order[i]);
    tick();
    tick();

    // Memory never answers: watchdog abort after TO-1 cycles of m_valid
    r0_valid = 1'b1; r0_wrd = 1'b0; r0_addr = 4'd5;
    cnt = 0; seen = 1'b0; e_err = 1'b0; e_data = '1;
    for (int c = 0; c < 60 && !seen; c++) begin
      tick();
      if (m_valid) cnt++;
      if (r0_ready) begin seen = 1'b1; e_err = r0_err; e_data = r0_rdata; end
    end
    r0_valid = 1'b0;
    chk("to_seen", seen, 1);
    chk("to_m_valid_cycles", cnt, 15);
    chk("to_err", e_err, 1);
    chk("to_rdata", e_data, 0);
    tick();

    // Reset two cycles into ISSUE abandons the access and restores r0 priority
    r0_valid = 1'b1; r0_addr = 4'd6;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_issue_m_valid", m_valid, 0);
    chk("rst_issue_r0_ready", r0_ready, 0);
    rst = 1'b0; r0_valid = 1'b0;
    any_rdy = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (r0_ready || r1_ready) any_rdy++;
    end
    chk("rst_issue_no_ready", any_rdy, 0);
    r0_valid = 1'b1; r0_addr = 4'd7;
    r1_valid = 1'b1; r1_addr = 4'd8;
    tick();
    chk("tie_after_rst_addr", m_addr, 7);
    m_ready = 1'b1;
    tick();
    chk("tie_after_rst_r0_ready", r0_ready, 1);
    r0_valid = 1'b0; r1_valid = 1'b0; m_ready = 1'b0;
    tick();
    tick();

    // m_ready while IDLE is ignored
    m_ready = 1'b1;
    tick();
    chk("idle_mrdy_m_valid", m_valid, 0);
    chk("idle_mrdy_r0_ready", r0_ready, 0);
    chk("idle_mrdy_r1_ready", r1_ready, 0);
    m_ready = 1'b0;
    tick();
    chk("idle_mrdy_r1_ready_2", r1_ready, 0);
    r1_valid = 1'b1; r1_wrd = 1'b0; r1_addr = 4'd3;
    tick();
    chk("idle_mrdy_then_grant", m_valid, 1);
    m_ready = 1'b1;
    tick();
    chk("idle_mrdy_then_rdata", r1_rdata, 8'hA5);
    r1_valid = 1'b0; m_ready = 1'b0;
    tick();

    // Randomized traffic, checked by the model every cycle
    wait_arm = 1'b0; lat = 0;
    for (int c = 0; c < 3000; c++) begin
      if (r0_valid && r0_ready) begin
        if ($urandom_range(0, 1) == 1) new_cmd(r0_wrd, r0_addr, r0_wdata);
        else r0_valid = 1'b0;
      end else if (!r0_valid && $urandom_range(0, 9) < 4) begin
        r0_valid = 1'b1;
        new_cmd(r0_wrd, r0_addr, r0_wdata);
      end
      if (r1_valid && r1_ready) begin
        if ($urandom_range(0, 1) == 1) new_cmd(r1_wrd, r1_addr, r1_wdata);
        else r1_valid = 1'b0;
      end else if (!r1_valid && $urandom_range(0, 9) < 4) begin
        r1_valid = 1'b1;
        new_cmd(r1_wrd, r1_addr, r1_wdata);
      end
      if (m_valid) begin
        if (!wait_arm) begin
          wait_arm = 1'b1;
          lat = ($urandom_range(0, 19) == 0) ? 100 : int'($urandom_range(0, 3));
        end
        m_ready = (lat == 0);
        if (lat > 0) lat--;
      end else begin
        wait_arm = 1'b0;
        m_ready = ($urandom_range(0, 9) == 0);
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0; m_ready = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout: simulation did not finish, required finish before %0t", $time);
    $fatal(1);
  end

endmodule
